// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS main control FSM and the datapath.
//   master : the control FSM (samples opcode/zero/mem_ready, drives selects and enables)
//   slave  : the datapath side (drives opcode/zero/mem_ready, consumes controls)
// Signals:
//   opcode[5:0] instr[31:26]; zero ALU zero flag; mem_ready memory access complete
//   iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
//   alu_src_b[1:0], alu_op[1:0], pc_src[1:0], pc_write, branch, pc_en, illegal_op,
//   state[3:0] (debug view of the FSM state)
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       branch;
  logic       pc_en;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_src, pc_write, branch, pc_en, illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_src, pc_write, branch, pc_en, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS32 datapath (Moore, 4-bit state).
// Sequences fetch/decode/execute/memory/writeback from the 6-bit opcode and drives
// datapath selects, write enables and the 2-bit ALU op class for the ALU control decoder.
// Ports:
//   clk   rising-edge clock
//   reset synchronous, active-high; forces every output to 0 while high
//   bus   mips_multicycle_control_if.master (opcode/zero/mem_ready in, controls out)
// Parameters:
//   USE_MEM_READY 1 = FETCH/MEMRD/MEMWR wait for mem_ready; 0 = mem_ready treated as 1
// Build option:
//   MIPS_CTRL_BNE_EN when defined, opcode 000101 (bne) decodes to BRANCH with an
//   inverted taken condition; otherwise it is an illegal opcode.
module mips_multicycle_control #(
  parameter int unsigned USE_MEM_READY = 1
) (
  input logic                        clk,
  input logic                        reset,
  mips_multicycle_control_if.master  bus
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  state_e state_q, state_d;
  logic   mem_rdy;
  logic   taken;

  assign mem_rdy = (USE_MEM_READY != 0) ? bus.mem_ready : 1'b1;

`ifdef MIPS_CTRL_BNE_EN
  logic bne_q;

  // Remembers that the branch in flight is bne so BRANCH inverts the zero test.
  always_ff @(posedge clk) begin
    if (reset) begin
      bne_q <= 1'b0;
    end else if (state_q == StDecode) begin
      bne_q <= (bus.opcode == OpBne);
    end else if (state_q == StBranch) begin
      bne_q <= 1'b0;
    end
  end

  assign taken = bus.zero ^ bne_q;
`else
  assign taken = bus.zero;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = StFetch;
    bus.iord       = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.pc_src     = 2'b00;
    bus.pc_write   = 1'b0;
    bus.branch     = 1'b0;
    bus.illegal_op = 1'b0;
    bus.state      = state_q;

    unique case (state_q)
      StFetch: begin
        bus.alu_src_b = 2'b01;
        bus.ir_write  = mem_rdy;
        bus.pc_write  = mem_rdy;
        state_d       = mem_rdy ? StDecode : StFetch;
      end
      StDecode: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
`ifdef MIPS_CTRL_BNE_EN
          OpBne:      state_d = StBranch;
`endif
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            bus.illegal_op = 1'b1;
            state_d        = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.opcode == OpSw) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        bus.iord = 1'b1;
        state_d  = mem_rdy ? StMemWb : StMemRd;
      end
      StMemWb: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
      end
      StMemWr: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
        state_d       = mem_rdy ? StFetch : StMemWr;
      end
      StExecute: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = StAluWb;
      end
      StAluWb: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
      end
      StBranch: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_src    = 2'b01;
        bus.branch    = 1'b1;
      end
      StAddiEx: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = StAddiWb;
      end
      StAddiWb: begin
        bus.reg_write = 1'b1;
      end
      StJump: begin
        bus.pc_src   = 2'b10;
        bus.pc_write = 1'b1;
      end
      // Unused codes 12-15: all controls stay 0, recover to FETCH.
      default: state_d = StFetch;
    endcase

    // Reset overrides everything so no write can escape an abandoned instruction.
    if (reset) begin
      bus.iord       = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_write  = 1'b0;
      bus.alu_src_a  = 1'b0;
      bus.alu_src_b  = 2'b00;
      bus.alu_op     = 2'b00;
      bus.pc_src     = 2'b00;
      bus.pc_write   = 1'b0;
      bus.branch     = 1'b0;
      bus.illegal_op = 1'b0;
      bus.state      = 4'd0;
    end

    bus.pc_en = bus.pc_write | (bus.branch & taken);
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
module tb_mips_multicycle_control;

  logic clk;
  logic reset;

  mips_multicycle_control_if bus ();

  mips_multicycle_control #(
    .USE_MEM_READY (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       pc_en;
    logic       illegal_op;
    logic [3:0] state;
  } out_t;

  typedef struct {
    out_t  exp;
    string name;
  } item_t;

  item_t q[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    cyc_no     = 0;

  // Expected outputs for one cycle. Per-state control constants are the hand-derived
  // table; mem_ready-dependent FETCH bits, pc_en and illegal_op are given by the caller.
  task automatic cyc(input logic rst, input logic [5:0] op, input logic mr, input logic z,
                     input logic [3:0] st, input logic ill, input logic pcen,
                     input string name);
    out_t e;
    item_t it;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.opcode    = op;
    bus.mem_ready = mr;
    bus.zero      = z;
    e = '0;
    case (st)
      4'd0:  begin e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
      4'd1:  e.alu_src_b = 2'b11;
      4'd2:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      4'd3:  e.iord = 1'b1;
      4'd4:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
      4'd5:  begin e.iord = 1'b1; e.mem_write = 1'b1; end
      4'd6:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
      4'd7:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
      4'd8:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.branch = 1'b1; end
      4'd9:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      4'd10: e.reg_write = 1'b1;
      4'd11: begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
      default: e = '0;
    endcase
    e.pc_en      = pcen;
    e.illegal_op = ill;
    e.state      = st;
    if (rst) e = '0;
    it.exp  = e;
    it.name = $sformatf("%s#%0d", name, cyc_no);
    cyc_no++;
    q.push_back(it);
  endtask

  // Monitor: every cycle with an outstanding expectation, compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      out_t  got;
      it  = q.pop_front();
      got = '{bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
              bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_src,
              bus.pc_write, bus.branch, bus.pc_en, bus.illegal_op, bus.state};
      compared++;
      if (got !== it.exp) begin
        mismatched++;
        $display("FAIL %s: got %06h (state %0d) expected %06h (state %0d)", it.name,
                 got, got.state, it.exp, it.exp.state);
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;

    // Reset held 3 cycles, then R-type.
    repeat (3) cyc(1, 6'b000000, 1, 0, 4'd0, 0, 0, "reset");
    cyc(0, 6'b000000, 1, 0, 4'd0, 0, 1, "rtype");
    cyc(0, 6'b000000, 1, 0, 4'd1, 0, 0, "rtype");
    cyc(0, 6'b000000, 1, 0, 4'd6, 0, 0, "rtype");
    cyc(0, 6'b000000, 1, 0, 4'd7, 0, 0, "rtype");

    // lw with FETCH stalled once and MEMRD stalled twice.
    cyc(0, 6'b100011, 0, 0, 4'd0, 0, 0, "lw_fstall");
    cyc(0, 6'b100011, 1, 0, 4'd0, 0, 1, "lw");
    cyc(0, 6'b100011, 1, 0, 4'd1, 0, 0, "lw");
    cyc(0, 6'b100011, 1, 0, 4'd2, 0, 0, "lw");
    cyc(0, 6'b100011, 0, 0, 4'd3, 0, 0, "lw_wait");
    cyc(0, 6'b100011, 0, 0, 4'd3, 0, 0, "lw_wait");
    cyc(0, 6'b100011, 1, 0, 4'd3, 0, 0, "lw");
    cyc(0, 6'b100011, 1, 0, 4'd4, 0, 0, "lw");

    // sw: one cycle of mem_write.
    cyc(0, 6'b101011, 1, 0, 4'd0, 0, 1, "sw");
    cyc(0, 6'b101011, 1, 0, 4'd1, 0, 0, "sw");
    cyc(0, 6'b101011, 1, 0, 4'd2, 0, 0, "sw");
    cyc(0, 6'b101011, 1, 0, 4'd5, 0, 0, "sw");

    // beq taken, then not taken.
    cyc(0, 6'b000100, 1, 1, 4'd0, 0, 1, "beq_t");
    cyc(0, 6'b000100, 1, 1, 4'd1, 0, 0, "beq_t");
    cyc(0, 6'b000100, 1, 1, 4'd8, 0, 1, "beq_t");
    cyc(0, 6'b000100, 1, 0, 4'd0, 0, 1, "beq_n");
    cyc(0, 6'b000100, 1, 0, 4'd1, 0, 0, "beq_n");
    cyc(0, 6'b000100, 1, 0, 4'd8, 0, 0, "beq_n");

    // addi and j.
    cyc(0, 6'b001000, 1, 0, 4'd0, 0, 1, "addi");
    cyc(0, 6'b001000, 1, 0, 4'd1, 0, 0, "addi");
    cyc(0, 6'b001000, 1, 0, 4'd9, 0, 0, "addi");
    cyc(0, 6'b001000, 1, 0, 4'd10, 0, 0, "addi");
    cyc(0, 6'b000010, 1, 0, 4'd0, 0, 1, "j");
    cyc(0, 6'b000010, 1, 0, 4'd1, 0, 0, "j");
    cyc(0, 6'b000010, 1, 0, 4'd11, 0, 1, "j");

    // Illegal opcode.
    cyc(0, 6'b111111, 1, 0, 4'd0, 0, 1, "ill");
    cyc(0, 6'b111111, 1, 0, 4'd1, 1, 0, "ill");

    // bne with zero=0.
    cyc(0, 6'b000101, 1, 0, 4'd0, 0, 1, "bne");
`ifdef MIPS_CTRL_BNE_EN
    cyc(0, 6'b000101, 1, 0, 4'd1, 0, 0, "bne");
    cyc(0, 6'b000101, 1, 0, 4'd8, 0, 1, "bne");
    // Following beq with zero=1 must use the plain taken sense again.
    cyc(0, 6'b000100, 1, 1, 4'd0, 0, 1, "beq_after_bne");
    cyc(0, 6'b000100, 1, 1, 4'd1, 0, 0, "beq_after_bne");
    cyc(0, 6'b000100, 1, 1, 4'd8, 0, 1, "beq_after_bne");
`else
    cyc(0, 6'b000101, 1, 0, 4'd1, 1, 0, "bne_ill");
`endif

    // Reset during MEMWR while memory is stalled.
    cyc(0, 6'b101011, 1, 0, 4'd0, 0, 1, "sw_rst");
    cyc(0, 6'b101011, 1, 0, 4'd1, 0, 0, "sw_rst");
    cyc(0, 6'b101011, 1, 0, 4'd2, 0, 0, "sw_rst");
    cyc(0, 6'b101011, 0, 0, 4'd5, 0, 0, "sw_rst_wait");
    cyc(1, 6'b101011, 0, 0, 4'd0, 0, 0, "sw_rst_cycle");
    cyc(0, 6'b101011, 0, 0, 4'd0, 0, 0, "post_rst");

    begin : drain
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin
        @(posedge clk);
        n++;
      end
      if (q.size() > 0) begin
        mismatched++;
        $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM of the multicycle MIPS32 datapath; sits directly upstream of the ALU control decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states from the 6-bit opcode.
- Drives datapath mux selects and write enables, plus the 2-bit ALU op class (00 add, 01 sub, 10 funct-decoded) consumed by the ALU control decoder.

Parameters:
- USE_MEM_READY, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, treated as always 1.

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instr[31:26] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- iord  out  1  0 = PC addresses memory, 1 = ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = memory data
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- alu_op  out  2  to ALU control decoder
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_write  out  1  unconditional PC write
- branch  out  1  conditional branch state
- pc_en  out  1  pc_write | (branch & taken)
- illegal_op  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state, for debug

Behaviour:
- Moore FSM, 4-bit state register. Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 go to FETCH on the next edge, with all outputs 0.
- Reset: state=FETCH on the next edge. While reset=1, every output is forced to 0, including all enables, selects, alu_op and illegal_op. Reset mid-instruction abandons it; no write enable may be high in the reset cycle.
- Outputs per state (unlisted outputs = 0):
  - FETCH: alu_src_b=01, ir_write=pc_write=mem_ready; stay until mem_ready=1, then DECODE.
  - DECODE: alu_src_b=11. Next state by opcode: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; else illegal_op=1 -> FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: iord=1; hold until mem_ready, then MEMWB.
  - MEMWB: mem_to_reg=1, reg_write=1 -> FETCH.
  - MEMWR: iord=1, mem_write=1 while in state; exit to FETCH in the cycle mem_ready=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
  - ALUWB: reg_dst=1, reg_write=1 -> FETCH.
  - BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1 -> FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10 -> ADDIWB.
  - ADDIWB: reg_write=1 -> FETCH.
  - JUMP: pc_src=10, pc_write=1 -> FETCH.
- ir_write and pc_write in FETCH are combinational on mem_ready; all other outputs depend on state only.
- taken = zero. pc_en is combinational.
- Cycle counts (mem_ready held high): lw 5; sw, R-type, addi 4; beq, j 3; illegal 2.
- opcode is sampled only in DECODE and MEMADR. It must be stable there; the IR is not written outside FETCH.

Optional Feature:
- Macro: MIPS_CTRL_BNE_EN.
- Defined: opcode 000101 decodes in DECODE to BRANCH. A registered flag bne_q is set on DECODE exit and cleared on BRANCH exit and on reset. taken = zero ^ bne_q.
- Undefined: 000101 is illegal (illegal_op pulse, return to FETCH), and taken = zero.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1, opcode=000000 -> all outputs 0 during reset; state sequence 0,1,6,7,0; alu_op=10 in state 6; reg_write=reg_dst=1 in state 7.
- lw (100011), mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; iord=1 throughout MEMRD; mem_to_reg=reg_write=1 in state 4.
- sw (101011), mem_ready=1 -> mem_write=1 for exactly 1 cycle in state 5; reg_write never 1.
- beq (000100), zero=1 then repeat with zero=0 -> pc_en=1 with pc_src=01 and alu_op=01 in state 8; second run pc_en=0.
- Opcode 111111 -> illegal_op=1 for 1 cycle in DECODE; no write enable set; FETCH on the next cycle. With MIPS_CTRL_BNE_EN, 000101 with zero=0 -> pc_en=1.
- Reset asserted during MEMWR -> mem_write=0 in the reset cycle; state=0 after the edge.
